data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 18 +
 rtl/data_memory.sv | 87 ++++++++
 tb/tb_data_memory.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Parameters shared by the L1 cache controller and its backing data memory.
// Covers line geometry, default memory latency and the memory FSM encoding.
package data_memory_pkg;

  localparam int unsigned CACHE_LINE_W  = 256;
  localparam int unsigned CACHE_DEPTH   = 512;
  localparam int unsigned CACHE_LATENCY = 10;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned OFFS_W        = 5;  // byte offset bits within one line
  localparam int unsigned CNT_W         = 8;  // enough for LATENCY up to 255

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// Fixed-latency line memory behind the L1 cache.
// Accepts one request at a time, stores or returns a whole line, and pulses ack_o once per request.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned LATENCY = CACHE_LATENCY,
  parameter int unsigned DEPTH   = CACHE_DEPTH,
  parameter int unsigned LINE_W  = CACHE_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] data_q;
  logic              ack_q;
  logic [LINE_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  idx_c;
  logic              accept_c;
  logic              done_c;
  logic              unused_addr_c;

  // Upper and offset address bits alias onto the same line.
  assign idx_c         = addr_i[OFFS_W +: IDX_W];
  assign unused_addr_c = ^{addr_i[ADDR_W-1:OFFS_W+IDX_W], addr_i[OFFS_W-1:0]};

  // ACK hands straight back to IDLE, so a held request is taken on the ACK exit edge.
  assign accept_c = enable_i && ((state_q == IDLE) || (state_q == ACK));
  assign done_c   = (state_q == WAIT) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE, ACK: begin
          if (accept_c) begin
            idx_q   <= idx_c;
            wr_q    <= write_i;
            wdata_q <= data_i;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (done_c) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (!wr_q) data_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset mid-request simply drops the commit.
  always_ff @(posedge clk) begin
    if (!rst && done_c && wr_q) mem_q[idx_q] <= wdata_q;
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a LATENCY=10 instance for function and reset,
// and a LATENCY=2 instance for back-to-back timing.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int unsigned LW = CACHE_LINE_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, wr, ack;
  logic [31:0]   addr;
  logic [LW-1:0] din, dout;
  logic          rst2, en2, wr2, ack2;
  logic [31:0]   addr2;
  logic [LW-1:0] din2, dout2;

  data_memory u_dut (
    .clk(clk), .rst(rst), .addr_i(addr), .data_i(din),
    .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout)
  );

  data_memory #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst2), .addr_i(addr2), .data_i(din2),
    .enable_i(en2), .write_i(wr2), .ack_o(ack2), .data_o(dout2)
  );

  int cyc = 0;
  int acks = 0;
  int acks2 = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ack)  acks  <= acks + 1;
    if (ack2) acks2 <= acks2 + 1;
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scan negedges for an ack; cycle stamp is -1 if none within the budget.
  task automatic wait_ack(input bit sel, output int c, output logic [LW-1:0] d);
    c = -1;
    d = '0;
    for (int i = 0; i < 60; i++) begin
      if ((sel ? ack2 : ack) === 1'b1) begin
        c = cyc;
        d = sel ? dout2 : dout;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [LW-1:0] d,
                     output int lat, output logic [LW-1:0] rd);
    int t0, c;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    wait_ack(1'b0, c, rd);
    en = 1'b0; wr = 1'b0;
    lat = (c < 0) ? -1 : c - t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] pa5, p2, p3, rd, rd1, rd2, ones, prev;
    int lat, t0, a1, a2, a0;

    pa5  = {32{8'hA5}};
    p2   = {4{64'h0123_4567_89AB_CDEF}};
    p3   = {8{32'hCAFE_F00D}};
    ones = '1;

    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rst2 = 1'b1; en2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", LW'(ack), '0);
    check("rst_dout", dout, '0);
    check("rst_dout2", dout2, '0);
    rst = 1'b0; rst2 = 1'b0;

    req(1'b0, 32'h0000_0040, '0, lat, rd);
    check("rd40_lat", LW'(lat), LW'(10));
    check("rd40_data", rd, '0);
    @(negedge clk); #1;
    check("rd40_ack_low_after", LW'(ack), '0);
    check("rd40_ack_count", LW'(acks), LW'(1));

    req(1'b1, 32'h0000_0120, pa5, lat, rd);
    check("wr120_lat", LW'(lat), LW'(10));
    check("wr120_hold", rd, '0);
    req(1'b0, 32'h0000_013C, '0, lat, rd);
    check("rd13c_lat", LW'(lat), LW'(10));
    check("rd13c_data", rd, pa5);

    prev = dout;
    req(1'b1, 32'h0000_4020, p2, lat, rd);
    check("wr4020_hold", rd, prev);
    req(1'b0, 32'h0000_0020, '0, lat, rd);
    check("rd20_alias", rd, p2);

    // Two requests with enable held; inputs disturbed mid-WAIT.
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h0000_0120; din = '0;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    repeat (4) @(negedge clk);
    addr = 32'h0000_0020; wr = 1'b1; din = ones;
    wait_ack(1'b0, a1, rd1);
    addr = 32'h0000_0020; wr = 1'b0; din = '0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    addr = 32'h0000_0120; wr = 1'b1; din = ones;
    wait_ack(1'b0, a2, rd2);
    en = 1'b0; wr = 1'b0;
    check("b2b_lat", LW'(a1 - t0), LW'(10));
    check("b2b_gap", LW'(a2 - a1), LW'(11));
    check("b2b_data1", rd1, pa5);
    check("b2b_data2", rd2, p2);
    req(1'b0, 32'h0000_013C, '0, lat, rd);
    check("b2b_no_stray_write", rd, pa5);

    // Reset five cycles into a write aborts it.
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0080; din = p3;
    @(posedge clk);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1; en = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 a0 = acks;
    repeat (15) @(negedge clk);
    #1;
    check("abort_no_ack", LW'(acks), LW'(a0));
    check("abort_dout_cleared", dout, '0);
    req(1'b0, 32'h0000_0080, '0, lat, rd);
    check("abort_lat_after", LW'(lat), LW'(10));
    check("abort_no_commit", rd, '0);
    @(negedge clk); #1;
    check("ack_total", LW'(acks), LW'(9));

    // LATENCY=2: write then read held back-to-back.
    @(negedge clk);
    en2 = 1'b1; wr2 = 1'b1; addr2 = 32'h0000_0040; din2 = pa5;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    wait_ack(1'b1, a1, rd1);
    wr2 = 1'b0; din2 = '0;
    @(negedge clk);
    wait_ack(1'b1, a2, rd2);
    en2 = 1'b0;
    check("l2_first_ack", LW'(a1 - t0), LW'(2));
    check("l2_write_hold", rd1, '0);
    check("l2_second_ack", LW'(a2 - t0), LW'(5));
    check("l2_read_data", rd2, pa5);
    repeat (5) @(negedge clk);
    #1;
    check("l2_ack_count", LW'(acks2), LW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
